// File: rtl/siggen_period_meter.sv
// Period / amplitude meter for the signal generator sample stream: averages the
// waveform period over 2^AVG_LOG2 cycles using hysteresis-qualified rising events.
module siggen_period_meter #(
    parameter int SAMPLE_W = 8,
    parameter int PERIOD_W = 16,
    parameter int AVG_LOG2 = 2,
    parameter int MID      = 128,
    parameter int HYST     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [PERIOD_W-1:0] period,
    output logic [SAMPLE_W-1:0] amp_min,
    output logic [SAMPLE_W-1:0] amp_max
);

    localparam int CW = PERIOD_W + AVG_LOG2;
    localparam int EW = AVG_LOG2 + 1;
    localparam logic [SAMPLE_W:0] TH_HI = (SAMPLE_W+1)'(MID + HYST);
    localparam logic [SAMPLE_W:0] TH_LO = (SAMPLE_W+1)'(MID - HYST);
    localparam logic [EW-1:0]     N_EVT = EW'(1 << AVG_LOG2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_MEAS,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_level;
    logic [CW-1:0]       r_cnt;
    logic [EW-1:0]       r_ecnt;
    logic [SAMPLE_W-1:0] r_wmin;
    logic [SAMPLE_W-1:0] r_wmax;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [PERIOD_W-1:0] r_period;
    logic [SAMPLE_W-1:0] r_amp_min;
    logic [SAMPLE_W-1:0] r_amp_max;

    logic                w_above;
    logic                w_below;
    logic                w_rise;
    logic                w_sat;
    logic                w_complete;
    logic [CW-1:0]       w_cnt_p1;
    logic [EW-1:0]       w_ecnt_nxt;
    logic [PERIOD_W-1:0] w_period;
    logic [SAMPLE_W-1:0] w_min_nxt;
    logic [SAMPLE_W-1:0] w_max_nxt;

    assign w_above    = {1'b0, sample_in} >= TH_HI;
    assign w_below    = {1'b0, sample_in} <= TH_LO;
    assign w_rise     = sample_valid && !r_level && w_above;
    assign w_sat      = &r_cnt;
    assign w_cnt_p1   = r_cnt + CW'(1);
    assign w_ecnt_nxt = r_ecnt + EW'(1);
    assign w_complete = w_rise && (w_ecnt_nxt == N_EVT);
    // cnt+1 spans exactly the averaged cycles; wrap at saturation truncates like the spec's PERIOD_W cut
    assign w_period   = w_cnt_p1[CW-1:AVG_LOG2];
    assign w_min_nxt  = (sample_valid && (sample_in < r_wmin)) ? sample_in : r_wmin;
    assign w_max_nxt  = (sample_valid && (sample_in > r_wmax)) ? sample_in : r_wmax;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
        end else if (sample_valid) begin
            if (w_above) begin
                r_level <= 1'b1;
            end else if (w_below) begin
                r_level <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ecnt    <= '0;
            r_wmin    <= '0;
            r_wmax    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_period  <= '0;
            r_amp_min <= '0;
            r_amp_max <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state   <= S_SYNC;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_cnt   <= '0;
                        r_ecnt  <= '0;
                        r_wmin  <= sample_in;
                        r_wmax  <= sample_in;
                    end else if (w_sat) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_period  <= '1;
                    end else begin
                        r_cnt <= w_cnt_p1;
                    end
                end
                S_MEAS: begin
                    r_wmin <= w_min_nxt;
                    r_wmax <= w_max_nxt;
                    if (w_complete || w_sat) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_amp_min <= w_min_nxt;
                        r_amp_max <= w_max_nxt;
                        // a completing event on the saturating cycle still yields a real period
                        r_timeout <= !w_complete;
                        r_period  <= w_complete ? w_period : '1;
                    end else begin
                        r_cnt <= w_cnt_p1;
                        if (w_rise) begin
                            r_ecnt <= w_ecnt_nxt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign period  = r_period;
    assign amp_min = r_amp_min;
    assign amp_max = r_amp_max;

endmodule

// File: tb/tb_siggen_period_meter.sv
// Bench for siggen_period_meter: randomized waveforms checked against an
// event-list model derived from the recorded sample stream.
module tb_siggen_period_meter;

    localparam int SW   = 8;
    localparam int PW   = 12;
    localparam int AL   = 2;
    localparam int MID  = 128;
    localparam int HYST = 8;
    localparam int CW   = PW + AL;
    localparam int SATC = 1 << CW;
    localparam int NAVG = 1 << AL;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [PW-1:0] period;
    logic [SW-1:0] amp_min;
    logic [SW-1:0] amp_max;

    siggen_period_meter #(
        .SAMPLE_W(SW),
        .PERIOD_W(PW),
        .AVG_LOG2(AL),
        .MID(MID),
        .HYST(HYST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .start(start),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .period(period),
        .amp_min(amp_min),
        .amp_max(amp_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] q_s[$];
    bit            q_v[$];

    int g_mode  = 0;
    int g_half  = 50;
    int g_lo    = 0;
    int g_hi    = 255;
    int g_vdiv  = 1;
    int g_noise = 0;
    int g_off   = 0;

    // mode 0: square, mode 1: ramp (+optional noise), otherwise constant g_lo
    function automatic logic [SW-1:0] gen(input int t);
        int v;
        case (g_mode)
            0:       v = (((t / g_half) % 2) == 1) ? g_hi : g_lo;
            1:       v = (t + g_off) % 256;
            default: v = g_lo;
        endcase
        if (g_noise > 0) v = v + int'($urandom_range(2 * g_noise)) - g_noise;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v[SW-1:0];
    endfunction

    task automatic step(input bit st);
        int t;
        t = q_s.size();
        sample_in    = gen(t);
        sample_valid = ((t % g_vdiv) == 0);
        start        = st;
        q_s.push_back(sample_in);
        q_v.push_back(sample_valid);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q_s.delete();
        q_v.delete();
    endtask

    // Expected outcome from the list of hysteresis rising events since reset.
    task automatic model(input int ts, output int e_done, output int e_per,
                         output int e_min, output int e_max, output bit e_to);
        int ev[$];
        bit flag;
        int k0;
        flag = 1'b0;
        k0   = -1;
        for (int i = 0; i < q_s.size(); i++) begin
            if (q_v[i]) begin
                if (!flag && q_s[i] >= MID + HYST) ev.push_back(i);
                if (q_s[i] >= MID + HYST) flag = 1'b1;
                else if (q_s[i] <= MID - HYST) flag = 1'b0;
            end
        end
        for (int k = 0; k < ev.size(); k++) begin
            if (k0 < 0 && ev[k] > ts) k0 = k;
        end
        e_to  = 1'b1;
        e_per = PMAX;
        e_min = 255;
        e_max = 0;
        if (k0 < 0 || ev[k0] > ts + SATC) begin
            e_done = ts + SATC;
        end else if (k0 + NAVG < ev.size() && ev[k0 + NAVG] - ev[k0] <= SATC) begin
            e_to   = 1'b0;
            e_done = ev[k0 + NAVG];
            e_per  = ((e_done - ev[k0]) >> AL) % (PMAX + 1);
            for (int i = ev[k0]; i <= e_done; i++) begin
                if (q_v[i]) begin
                    if (q_s[i] < e_min) e_min = q_s[i];
                    if (q_s[i] > e_max) e_max = q_s[i];
                end
            end
        end else begin
            e_done = ev[k0] + SATC;
        end
    endtask

    task automatic run_check(input string name, input int start_at, input int extra_at);
        int t;
        int done_t;
        int e_done, e_per, e_min, e_max;
        bit e_to;
        done_t = -1;
        while (done_t < 0) begin
            t = q_s.size();
            if (t > start_at + 2 * SATC + 16) begin
                checks++;
                errors++;
                $display("FAIL %s done_wait: no done seen, required within %0d cycles", name, 2 * SATC);
                return;
            end
            step(t == start_at || t == extra_at);
            if (t == start_at) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
                end
            end
            if (done === 1'b1) done_t = t;
        end
        model(start_at, e_done, e_per, e_min, e_max, e_to);
        checks++;
        if (done_t != e_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_t, e_done);
        end
        checks++;
        if (timeout !== e_to) begin
            errors++;
            $display("FAIL %s timeout: got %b expected %b", name, timeout, e_to);
        end
        checks++;
        if (period !== e_per[PW-1:0]) begin
            errors++;
            $display("FAIL %s period: got %0d expected %0d", name, period, e_per);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        end
        if (!e_to) begin
            checks++;
            if (amp_min !== e_min[SW-1:0] || amp_max !== e_max[SW-1:0]) begin
                errors++;
                $display("FAIL %s amp: got min %0d max %0d expected min %0d max %0d",
                         name, amp_min, amp_max, e_min, e_max);
            end
        end
    endtask

    task automatic set_square(input int half, input int lo, input int hi, input int vdiv);
        g_mode  = 0;
        g_half  = half;
        g_lo    = lo;
        g_hi    = hi;
        g_vdiv  = vdiv;
        g_noise = 0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        sample_in    = 8'd200;
        sample_valid = 1'b1;
        start        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags: got busy/done/timeout %b expected 000", {busy, done, timeout});
        end
        checks++;
        if (period !== '0 || amp_min !== '0 || amp_max !== '0) begin
            errors++;
            $display("FAIL reset results: got period %0d min %0d max %0d expected 0 0 0",
                     period, amp_min, amp_max);
        end
        do_reset();
    endtask

    task automatic test_square();
        set_square(50, 0, 255, 1);
        run_check("square_fixed", q_s.size() + 3, -1);
        for (int n = 0; n < 3; n++) begin
            step(1'b0);
            set_square(int'($urandom_range(120, 20)), int'($urandom_range(100, 0)),
                       int'($urandom_range(255, 160)), 1);
            run_check("square_rand", q_s.size() + int'($urandom_range(20, 1)), -1);
        end
    endtask

    task automatic test_sparse_valid();
        do_reset();
        set_square(64, 0, 255, 4);
        run_check("sparse_fixed", 4, -1);
        step(1'b0);
        set_square(int'($urandom_range(100, 30)), 10, 240, int'($urandom_range(5, 2)));
        run_check("sparse_rand", q_s.size() + 5, -1);
    endtask

    task automatic test_ramp();
        do_reset();
        g_mode  = 1;
        g_vdiv  = 1;
        g_noise = 0;
        g_off   = int'($urandom_range(255));
        run_check("ramp", 2, -1);
        step(1'b0);
        g_noise = 5;
        run_check("ramp_noise", q_s.size() + 7, -1);
        g_noise = 0;
    endtask

    task automatic test_start_ignored();
        int s;
        step(1'b0);
        set_square(int'($urandom_range(80, 30)), 0, 255, 1);
        s = q_s.size() + 2;
        run_check("start_in_measure", s, s + 5 * g_half);
    endtask

    task automatic test_back_to_back();
        step(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy %b expected 0", busy);
        end
        run_check("back_to_back", q_s.size(), -1);
    endtask

    task automatic test_rst_mid();
        int s;
        step(1'b0);
        set_square(50, 0, 255, 1);
        s = q_s.size() + 2;
        while (q_s.size() <= s + 300) step(q_s.size() == s);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || period !== '0) begin
            errors++;
            $display("FAIL rst_mid: got busy %b done %b timeout %b period %0d expected 0 0 0 0",
                     busy, done, timeout, period);
        end
        do_reset();
        run_check("after_rst", 3, -1);
    endtask

    task automatic test_timeouts();
        do_reset();
        g_mode = 2;
        g_lo   = 200;
        g_vdiv = 1;
        run_check("const_sync_timeout", 3, -1);
        do_reset();
        set_square(2500, 0, 255, 1);
        run_check("long_period_timeout", 3, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_square();
        test_back_to_back();
        test_start_ignored();
        test_rst_mid();
        test_sparse_valid();
        test_ramp();
        test_timeouts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/siggen_period_meter.md
Name: siggen_period_meter

Overview:
- Receive-side companion to the multimode signal generator.
- Consumes the 8-bit sample stream the generator drives onto its R2R DAC, either looped back digitally or taken from an ADC.
- Measures the waveform period in clock cycles, averaged over 2^AVG_LOG2 cycles, and captures the min/max amplitude.
- Gives on-chip and bench self-check of generator frequency and mode settings.

Parameters:
- SAMPLE_W, 8: sample width.
- PERIOD_W, 16: width of the reported period.
- AVG_LOG2, 2: log2 of the number of waveform cycles averaged (default 4 cycles).
- MID, 128: crossing threshold centre.
- HYST, 8: hysteresis half-band.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sample_in  in  SAMPLE_W  waveform sample.
- sample_valid  in  1  sample_in is valid this cycle.
- start  in  1  single-cycle pulse that begins a measurement.
- busy  out  1  measurement in progress.
- done  out  1  single-cycle pulse when results update.
- timeout  out  1  last measurement saturated; held with the results.
- period  out  PERIOD_W  averaged period in clk cycles.
- amp_min  out  SAMPLE_W  minimum sample seen during MEASURE.
- amp_max  out  SAMPLE_W  maximum sample seen during MEASURE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - busy, done, timeout = 0; period = 0; amp_min = 0; amp_max = 0.
  - Internal level flag = 0 (low).
- Level flag:
  - Updated only on valid samples.
  - Set when sample_in >= MID+HYST.
  - Cleared when sample_in <= MID-HYST.
  - Samples inside the band hold the flag.
  - The flag runs in all states, including IDLE.
- Rising event: a cycle with sample_valid=1 where the flag is 0 and sample_in >= MID+HYST. Combinational from the current sample and the registered flag.
- Cycle counter: CW = PERIOD_W+AVG_LOG2 bits. Event counter: AVG_LOG2+1 bits.
- FSM states:
  - IDLE:
    - start=1 → SYNC; busy=1 from the next cycle.
    - Cycle counter cleared; timeout cleared.
    - Results hold their previous values.
  - SYNC:
    - Cycle counter increments every clk.
    - On a rising event → MEASURE: cycle counter := 0, event counter := 0, amp_min := sample_in, amp_max := sample_in.
    - If the counter reaches all-ones first → DONE with timeout=1.
  - MEASURE:
    - Cycle counter increments every clk.
    - Each valid sample updates amp_min/amp_max (unsigned compare).
    - On each rising event, the event counter increments.
    - When the event counter reaches 2^AVG_LOG2 → period := (cnt+1) >> AVG_LOG2, truncated to PERIOD_W, then go to DONE.
    - If the counter reaches all-ones before that → period := all-ones, timeout := 1, go to DONE.
  - DONE:
    - done=1 for exactly this one cycle; busy=0 during it.
    - Returns to IDLE next cycle.
- busy = 1 in SYNC and MEASURE only.
- start while busy or in DONE is ignored. There is no abort other than rst.
- Simultaneous events:
  - Rising event and saturation in the same cycle: the event wins if it completes the count; otherwise timeout.
  - start and a rising event in the IDLE cycle: the event is not used for sync; sync waits for the next rising event.
- sample_valid=0 cycles:
  - Still advance the cycle counter (period is in clk units).
  - Do not update the flag or min/max.
- Reset mid-measurement: immediate return to reset values; any partial result is discarded.
- Latency: done asserts the cycle after the terminating rising event. period/amp_*/timeout become valid in the same cycle done asserts and hold until the next done or rst.

Test Plan:
- Square wave, 0/255 alternating every 50 clks, sample_valid=1 always, start pulse → done after 5 rising edges; period=100, amp_min=0, amp_max=255, timeout=0.
- Same square wave with sample_valid asserted every 4th clk, half-period 64 → period=128 (clk units, not samples).
- Ramp 0..255 step 1 per clk, wrapping to 0 → period=256, amp_min=0, amp_max=255. Noise of ±5 LSB around 128 adds no extra events, because of hysteresis.
- Constant sample_in=200, start → SYNC saturates after 2^18 clks; done with timeout=1, period=16'hFFFF.
- start during MEASURE → ignored, and the result matches a clean run. rst asserted mid-MEASURE → busy=0 and period=0 immediately; a new start then completes normally.
- Square wave with period 70000 clks → timeout=1, period=16'hFFFF.
